// File: rtl/sbox_round_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbox_round_seq_pkg                                                    |
// | FSM encodings, default round parameters and the 4-bit column sbox.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package sbox_round_seq_pkg;

    localparam int NR_DEFAULT = 16;
    localparam int CW_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Nibble bit 0 is the slice0 bit of a column, bit 3 the slice3 bit.
    function automatic logic [3:0] col_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;
            4'h1: y = 4'hA;
            4'h2: y = 4'h4;
            4'h3: y = 4'hC;
            4'h4: y = 4'h6;
            4'h5: y = 4'hF;
            4'h6: y = 4'h3;
            4'h7: y = 4'h9;
            4'h8: y = 4'h2;
            4'h9: y = 4'hD;
            4'hA: y = 4'hB;
            4'hB: y = 4'h7;
            4'hC: y = 4'h5;
            4'hD: y = 4'h0;
            4'hE: y = 4'h8;
            default: y = 4'hE;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_round_seq_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbox                                                                  |
// | 64-bit bitsliced sbox layer: 16 columns of one bit from each slice.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sbox
    import sbox_round_seq_pkg::*;
(
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    for (genvar i = 0; i < 16; i++) begin : g_col
        logic [3:0] w_col_out;
        assign w_col_out = col_sbox({i_data[i], i_data[16+i], i_data[32+i], i_data[48+i]});
        assign o_data[48+i] = w_col_out[0];
        assign o_data[32+i] = w_col_out[1];
        assign o_data[16+i] = w_col_out[2];
        assign o_data[i]    = w_col_out[3];
    end

endmodule
`default_nettype wire

// File: rtl/sbox_round_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbox_round_seq                                                        |
// | Iterative NR-round sbox(state ^ rk) sequencer with valid/ready ports. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sbox_round_seq
    import sbox_round_seq_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [CW-1:0] rnd,
    input  logic [63:0]   rk,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);

    localparam logic [CW-1:0] C_LAST_RND = CW'(NR - 1);

    fsm_t          r_fsm;
    logic [63:0]   r_state;
    logic [CW-1:0] r_rnd;
    logic          r_din_ready;
    logic          r_dout_valid;
    logic          r_busy;
    logic [63:0]   w_sbox_in;
    logic [63:0]   w_sbox_out;

    // The round key arrives combinationally for the current r_rnd.
    assign w_sbox_in = r_state ^ rk;

    sbox u_sbox (
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= ST_IDLE;
            r_state      <= 64'h0;
            r_rnd        <= '0;
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (din_valid) begin
                        r_state     <= din;
                        r_rnd       <= '0;
                        r_fsm       <= ST_RUN;
                        r_din_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= w_sbox_out;
                    if (r_rnd == C_LAST_RND) begin
                        r_fsm        <= ST_DONE;
                        r_dout_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (dout_ready) begin
                        r_fsm        <= ST_IDLE;
                        r_dout_valid <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding recovers to IDLE without accepting.
                    r_fsm        <= ST_IDLE;
                    r_din_ready  <= 1'b1;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = r_din_ready;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign rnd        = r_rnd;
    assign dout       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sbox_round_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sbox_round_seq                                                     |
// | Four sequencers (NR=1..4) against a column-table reference model.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sbox_round_seq;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst        [ND];
    logic [63:0] din        [ND];
    logic        din_valid  [ND];
    logic        din_ready  [ND];
    logic [4:0]  rnd        [ND];
    logic [63:0] rk         [ND];
    logic [63:0] dout       [ND];
    logic        dout_valid [ND];
    logic        dout_ready [ND];
    logic        busy       [ND];
    logic [63:0] keys       [ND][32];

    int cyc = 0;
    int nchk = 0;
    int npass = 0;
    int ntimeout = 0;

    bit          have_job [ND];
    int          t_acc    [ND];
    logic [63:0] res      [ND];
    bit          was_rst  [ND];
    int          last_acc [ND];
    bit          b2b_on   [ND];
    bit          lit_on   [ND];
    logic [63:0] lit_exp  [ND];

    int tab [16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sbox_round_seq #(.NR(g + 1), .CW(5)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .din        (din[g]),
            .din_valid  (din_valid[g]),
            .din_ready  (din_ready[g]),
            .rnd        (rnd[g]),
            .rk         (rk[g]),
            .dout       (dout[g]),
            .dout_valid (dout_valid[g]),
            .dout_ready (dout_ready[g]),
            .busy       (busy[g])
        );
        assign rk[g] = keys[g][rnd[g]];
    end

    // Slice j is the 16-bit word j from the top; column value = sum of slice bits << j.
    function automatic logic [63:0] sb(logic [63:0] x);
        logic [15:0] s [4];
        logic [15:0] o [4];
        int v;
        int w;
        for (int j = 0; j < 4; j++) s[j] = x[63-16*j -: 16];
        for (int i = 0; i < 16; i++) begin
            v = 0;
            for (int j = 0; j < 4; j++) if (s[j][i]) v += (1 << j);
            w = tab[v];
            for (int j = 0; j < 4; j++) o[j][i] = w[j];
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    function automatic logic [63:0] model_block(logic [63:0] blk, int k);
        logic [63:0] b;
        b = blk;
        for (int r = 0; r < k + 1; r++) b = sb(b ^ keys[k][r]);
        return b;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, cyc, act, exp);
    endtask

    // Single compare process: check this cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        int nr;
        if (cyc == 2) begin
            check("pin_sb_zero", 0, sb(64'h0), 64'hFFFF_0000_0000_0000);
            check("pin_sb_twice", 0, sb(sb(64'h0)), 64'h0000_FFFF_0000_FFFF);
            check("pin_sb_a", 0, sb(64'h0000_FFFF_0000_FFFF), 64'hFFFF_FFFF_0000_FFFF);
            check("pin_sb_col0", 0, sb(64'h0001_0000_0000_0000), 64'hFFFE_0001_0000_0001);
        end
        for (int k = 0; k < ND; k++) begin
            nr = k + 1;
            if (was_rst[k]) check("reset_state", k, dout[k], 64'h0);
            if (!have_job[k]) begin
                check("din_ready_idle", k, 64'(din_ready[k]), 64'd1);
                check("dout_valid_idle", k, 64'(dout_valid[k]), 64'd0);
                check("busy_idle", k, 64'(busy[k]), 64'd0);
            end else if (cyc < t_acc[k] + nr) begin
                check("din_ready_run", k, 64'(din_ready[k]), 64'd0);
                check("dout_valid_run", k, 64'(dout_valid[k]), 64'd0);
                check("busy_run", k, 64'(busy[k]), 64'd1);
                check("rnd", k, 64'(rnd[k]), 64'(cyc - t_acc[k]));
            end else begin
                check("din_ready_done", k, 64'(din_ready[k]), 64'd0);
                check("dout_valid_done", k, 64'(dout_valid[k]), 64'd1);
                check("busy_done", k, 64'(busy[k]), 64'd1);
                check("dout", k, dout[k], res[k]);
                if (lit_on[k]) check("dout_literal", k, dout[k], lit_exp[k]);
            end

            was_rst[k] = rst[k];
            if (!b2b_on[k]) last_acc[k] = -1;
            if (rst[k]) begin
                have_job[k] = 1'b0;
            end else if (!have_job[k]) begin
                if (din_valid[k]) begin
                    have_job[k] = 1'b1;
                    t_acc[k]    = cyc + 1;
                    res[k]      = model_block(din[k], k);
                    if (b2b_on[k]) begin
                        if (last_acc[k] >= 0)
                            check("b2b_spacing", k, 64'(cyc + 1 - last_acc[k]), 64'(nr + 2));
                        last_acc[k] = cyc + 1;
                    end
                end
            end else if (cyc >= t_acc[k] + nr && dout_ready[k]) begin
                have_job[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int k, logic [63:0] d);
        int n;
        n = 0;
        din[k] = d;
        din_valid[k] = 1'b1;
        while (!din_ready[k] && n < 100) begin
            tick();
            n++;
        end
        tick();
        din_valid[k] = 1'b0;
        if (n >= 100) begin
            ntimeout++;
            $display("FAIL send_timeout dut%0d: din_ready never high", k);
        end
    endtask

    task automatic wait_valid(int k);
        int n;
        n = 0;
        while (!dout_valid[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            ntimeout++;
            $display("FAIL valid_timeout dut%0d: dout_valid never high", k);
        end
    endtask

    initial begin
        for (int k = 0; k < ND; k++) begin
            rst[k] = 1'b1;
            din[k] = 64'h0;
            din_valid[k] = 1'b0;
            dout_ready[k] = 1'b0;
            b2b_on[k] = 1'b0;
            lit_on[k] = 1'b0;
            lit_exp[k] = 64'h0;
            have_job[k] = 1'b0;
            was_rst[k] = 1'b0;
            last_acc[k] = -1;
            t_acc[k] = 0;
            res[k] = 64'h0;
            for (int r = 0; r < 32; r++) keys[k][r] = 64'h0;
        end
        repeat (3) tick();
        for (int k = 0; k < ND; k++) rst[k] = 1'b0;
        tick();

        // NR=1, zero block and key
        dout_ready[0] = 1'b1;
        lit_exp[0] = 64'hFFFF_0000_0000_0000;
        lit_on[0] = 1'b1;
        send(0, 64'h0);
        wait_valid(0);
        tick();
        lit_on[0] = 1'b0;

        // NR=2, zero block and keys
        dout_ready[1] = 1'b1;
        lit_exp[1] = 64'h0000_FFFF_0000_FFFF;
        lit_on[1] = 1'b1;
        send(1, 64'h0);
        wait_valid(1);
        tick();
        lit_on[1] = 1'b0;

        // NR=1, key folded in before the sbox
        keys[0][0] = 64'hFFFF_0000_0000_0000;
        lit_exp[0] = 64'h0000_FFFF_0000_FFFF;
        lit_on[0] = 1'b1;
        send(0, 64'h0);
        wait_valid(0);
        tick();
        lit_on[0] = 1'b0;

        // Backpressure on NR=4 with an ignored din_valid pulse
        for (int r = 0; r < 4; r++) keys[3][r] = rand64();
        dout_ready[3] = 1'b0;
        send(3, rand64());
        wait_valid(3);
        tick();
        din[3] = rand64();
        din_valid[3] = 1'b1;
        tick();
        din_valid[3] = 1'b0;
        repeat (3) tick();
        dout_ready[3] = 1'b1;
        tick();
        dout_ready[3] = 1'b0;
        tick();

        // Reset during RUN at rnd=1, then a normal block
        send(3, rand64());
        begin
            int n;
            n = 0;
            while (rnd[3] != 5'd1 && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) begin
                ntimeout++;
                $display("FAIL rnd_timeout dut3: rnd never reached 1");
            end
        end
        rst[3] = 1'b1;
        tick();
        rst[3] = 1'b0;
        dout_ready[3] = 1'b1;
        send(3, rand64());
        wait_valid(3);
        tick();

        // Back-to-back on NR=3
        for (int r = 0; r < 3; r++) keys[2][r] = rand64();
        b2b_on[2] = 1'b1;
        dout_ready[2] = 1'b1;
        din_valid[2] = 1'b1;
        repeat (50) begin
            din[2] = rand64();
            tick();
        end
        din_valid[2] = 1'b0;
        repeat (8) tick();
        b2b_on[2] = 1'b0;

        // Random traffic on all instances; keys change only while idle
        repeat (400) begin
            for (int k = 0; k < ND; k++) begin
                if (!have_job[k]) begin
                    for (int r = 0; r < k + 1; r++) keys[k][r] = rand64();
                    din[k] = rand64();
                end
                din_valid[k] = ($urandom_range(0, 2) == 0);
                dout_ready[k] = $urandom_range(0, 1) == 1;
                rst[k] = (k == 3) && ($urandom_range(0, 40) == 0);
            end
            tick();
        end
        for (int k = 0; k < ND; k++) begin
            din_valid[k] = 1'b0;
            dout_ready[k] = 1'b1;
            rst[k] = 1'b0;
        end
        repeat (10) tick();

        $display("%0d/%0d checks passed", npass, nchk + ntimeout);
        $finish;
    end

endmodule
`default_nettype wire
